// File: rtl/multiplier_4bit.sv
// Iterative radix-2 Booth multiplier, 4x4 signed -> 8-bit signed product.
// One multiplier bit is retired per cycle; the result is ready 4 cycles after start is accepted.
module multiplier_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] mul_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nx;
    logic [3:0] mcand, q;
    logic [4:0] acc;
    logic       qm1;
    logic [1:0] cnt;

    logic [4:0] mext, sum, acc_nx;
    logic [3:0] q_nx;
    logic       qm1_nx;

    // One Booth step. The accumulator is one bit wider than the operands so that
    // subtracting -8 cannot overflow.
    always_comb begin
        mext = {mcand[3], mcand};
        sum  = acc;
        case ({q[0], qm1})
            2'b01:   sum = acc + mext;
            2'b10:   sum = acc - mext;
            default: sum = acc;
        endcase
        acc_nx = {sum[4], sum[4:1]};
        q_nx   = {sum[0], q[3:1]};
        qm1_nx = q[0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == 2'd3) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            q       <= '0;
            acc     <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
            mul_out <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    mcand <= a;
                    q     <= b;
                    acc   <= '0;
                    qm1   <= 1'b0;
                    cnt   <= '0;
                end
                RUN: begin
                    acc <= acc_nx;
                    q   <= q_nx;
                    qm1 <= qm1_nx;
                    cnt <= cnt + 2'd1;
                    // After the 4th shift the product sits in {acc, q}; the low 8 bits are exact.
                    if (cnt == 2'd3) mul_out <= {acc_nx[3:0], q_nx};
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_multiplier_4bit.sv
// Scoreboard bench for multiplier_4bit: a cycle model predicts busy/done/mul_out,
// products are queued on accept and popped when done is expected.
module tb_multiplier_4bit;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] a, b;
    logic       busy, done;
    logic [7:0] mul_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb_q[$];
    int         m_ph  = 0;      // 0 idle, 1..4 run, 5 done
    logic [7:0] m_out = 8'h00;

    multiplier_4bit dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .mul_out(mul_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [7:0] ref_prod(input logic [3:0] x, input logic [3:0] y);
        int p;
        p = $signed(x) * $signed(y);
        return p[7:0];
    endfunction

    // Reference model advances on the edge, DUT outputs checked 1 time unit later.
    always @(posedge clk) begin
        if (rst) begin
            m_ph  = 0;
            m_out = 8'h00;
            sb_q.delete();
        end else if (m_ph == 0) begin
            if (start) begin
                m_ph = 1;
                sb_q.push_back(ref_prod(a, b));
            end
        end else if (m_ph == 5) begin
            m_ph = 0;
        end else begin
            m_ph++;
            if (m_ph == 5) begin
                if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
                else m_out = sb_q.pop_front();
            end
        end
        #1;
        chk("busy", int'(busy), int'(m_ph != 0));
        chk("done", int'(done), int'(m_ph == 5));
        chk("mul_out", int'(mul_out), int'(m_out));
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Issue one op from idle, scramble operands during RUN, return on the edge before next accept.
    task automatic do_op(input logic [3:0] x, input logic [3:0] y);
        a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        a = 4'($urandom); b = 4'($urandom);
        repeat (5) tick();
    endtask

    logic [3:0] da[10] = '{4'b1010, 4'd3, 4'hF, 4'd2, 4'd7, 4'hC, 4'hB, 4'h8, 4'h8, 4'd0};
    logic [3:0] db[10] = '{4'b1111, 4'd5, 4'hF, 4'hE, 4'h9, 4'hD, 4'hE, 4'h8, 4'd7, 4'd0};

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) tick();
        // reset beats start when both are high
        start = 1'b1; a = 4'd3; b = 4'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) do_op(da[i], db[i]);

        // start held high with operands changing every cycle
        start = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (6) tick();

        // make mul_out non-zero, then abort 7*-7 at its second iteration
        do_op(4'd3, 4'd5);
        a = 4'd7; b = 4'h9; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_out", int'(mul_out), 0);
        repeat (6) tick();

        for (int i = 0; i < 256; i++) do_op(4'(i >> 4), 4'(i));

        repeat (2) tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multiplier_4bit.md
MULTIPLIER_4BIT -- requirements
Module: multiplier_4bit

Interface
Parameters: none; all widths are fixed as listed below.
REQ-001 clk  input  1  Single clock; all state SHALL update on the rising edge only.
REQ-002 rst  input  1  Synchronous, active-high reset; sampled on the rising clk edge.
REQ-003 start  input  1  Request pulse; a new multiply SHALL begin when start=1 is sampled while busy=0.
REQ-004 a  input  4  Multiplicand, signed two's complement, range -8..+7.
REQ-005 b  input  4  Multiplier, signed two's complement, range -8..+7.
REQ-006 busy  output  1  SHALL be high whenever an operation is in progress (state RUN or DONE).
REQ-007 done  output  1  SHALL be a single-cycle pulse that marks mul_out as newly valid.
REQ-008 mul_out  output  8  Signed two's complement product of a and b; registered.

Function
REQ-009 The multiplier SHALL be iterative radix-2 Booth, processing one multiplier bit per cycle over 4 iterations.
REQ-010 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions:
- IDLE to RUN on start=1.
- RUN to DONE after the 4th iteration.
- DONE to IDLE unconditionally after one cycle.
REQ-011 On the start-accept edge N, a and b SHALL be captured into internal registers, the accumulator SHALL be cleared, and the iteration count SHALL be set to 0.
REQ-012 Changes on a and b after edge N SHALL NOT affect the result in progress.
REQ-013 Edges N+1 through N+4 SHALL each perform one Booth step:
- examine bit pair {q0, q-1};
- add or subtract the sign-extended multiplicand into an accumulator of at least 5 bits;
- arithmetic-shift-right the combined {acc, q, q-1}.
REQ-014 At edge N+4 the FSM SHALL enter DONE and load mul_out with the full 8-bit signed product.
REQ-015 done SHALL be 1 for exactly the single cycle between edges N+4 and N+5; fixed latency is 4 cycles from start accept to done.
REQ-016 mul_out SHALL hold its value until the next completion or reset, and SHALL NOT change during RUN.
REQ-017 start asserted while busy=1 (RUN or DONE) SHALL be ignored and SHALL NOT be queued.
REQ-018 Back-to-back throughput: a start sampled on the edge that returns to IDLE (N+5) SHALL be ignored; the earliest new accept is edge N+6.
REQ-019 The result SHALL be exact for all 256 operand pairs, including -8*-8 = +64 (0x40) and -8*7 = -56 (0xC8); no overflow or saturation is possible.
REQ-020 The multiplier SHALL be combinational-loop free, use no latches, and use no vendor multiplier primitives.

Reset
REQ-021 When rst=1 is sampled, the block SHALL enter IDLE with busy=0, done=0, mul_out=0x00, and all internal registers cleared.
REQ-022 rst SHALL override start when both are sampled high on the same edge.
REQ-023 rst asserted mid-operation (RUN or DONE) SHALL abort the operation with no done pulse; the partial result SHALL be discarded and mul_out SHALL be 0x00.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- a=1010 (-6), b=1111 (-1), start pulse -> done exactly 4 cycles after accept, mul_out=0x06 (+6).
- Sequential ops: 3*5 -> 0x0F (15); -1*-1 -> 0x01; 2*-2 -> 0xFC (-4); 7*-7 -> 0xCF (-49); -4*-3 -> 0x0C (12); -5*-2 -> 0x0A (10).
- Corner operands: -8*-8 -> 0x40 (64); -8*7 -> 0xC8 (-56).
- start held high continuously -> one operation per 6 cycles; operand changes during RUN do not alter the result; done is never wider than 1 cycle.
- rst pulsed at iteration 2 of 7*-7 -> no done pulse; mul_out=0x00; busy=0 on the next cycle.
- Exhaustive sweep of all 256 pairs -> mul_out equals the signed reference product every time.
